// File: rtl/dqs_dly_calib.sv
// dqs_dly_calib: per-lane delay calibration sequencer for the DQS/DQ test path.
//
// Sweeps one shared delay code 0..DLY_MAX across every lane. Each step loads and
// sets the delay lines, waits for the path to settle, then compares each lane's
// deserialized word against PATTERN. Each lane records its first contiguous
// passing window. At the end, every passing lane is loaded with its window centre.
//
// Ports:
//   clk      divided clock, rising edge
//   rst      asynchronous active-low reset
//   start    begin a sweep (only honoured while idle)
//   rx_data  deserialized words, lane i at [4i+3:4i]
//   dly      delay code presented to all delay lines (registered)
//   ld       per-lane load strobe for dly (registered)
//   set      apply loaded delays in all lanes (registered)
//   busy     high whenever the sequencer is not idle
//   done     one-cycle pulse at sweep completion (registered)
//   lane_ok  lane found at least one passing step
//   win_lo   per-lane first code of the first passing run
//   win_hi   per-lane last code of the first passing run
//   center   per-lane (win_lo + win_hi) >> 1

module dqs_dly_calib #(
  parameter int unsigned NUM_LANES     = 4,
  parameter int unsigned DLY_WIDTH     = 8,
  parameter int unsigned DLY_MAX       = 255,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned SAMPLE_CYCLES = 64,
  parameter logic [3:0]  PATTERN       = 4'b0101
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [4*NUM_LANES-1:0]         rx_data,
  output logic [DLY_WIDTH-1:0]           dly,
  output logic [NUM_LANES-1:0]           ld,
  output logic                           set,
  output logic                           busy,
  output logic                           done,
  output logic [NUM_LANES-1:0]           lane_ok,
  output logic [DLY_WIDTH*NUM_LANES-1:0] win_lo,
  output logic [DLY_WIDTH*NUM_LANES-1:0] win_hi,
  output logic [DLY_WIDTH*NUM_LANES-1:0] center
);

  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES
                                                                     : SAMPLE_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned IDX_W   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  localparam logic [DLY_WIDTH-1:0] LAST_CODE   = DLY_WIDTH'(DLY_MAX);
  localparam logic [CNT_W-1:0]     SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]     SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [IDX_W-1:0]     LANE_LAST   = IDX_W'(NUM_LANES - 1);

  typedef enum logic [3:0] {
    StIdle,
    StLoad,
    StSet,
    StSettle,
    StSample,
    StNext,
    StApply,
    StApplySet,
    StDone
  } state_e;

  typedef logic [NUM_LANES-1:0][DLY_WIDTH-1:0] code_arr_t;

  state_e               state_q;
  logic [DLY_WIDTH-1:0] cur_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic [NUM_LANES-1:0] fail_q;
  logic [NUM_LANES-1:0] found_q;
  logic [NUM_LANES-1:0] in_run_q;
  code_arr_t            win_lo_q;
  code_arr_t            win_hi_q;
  logic [DLY_WIDTH-1:0] dly_q;
  logic [NUM_LANES-1:0] ld_q;
  logic                 set_q;
  logic                 done_q;

  // Window state as it will be after the current step's NEXT update.
  logic [NUM_LANES-1:0] found_d;
  logic [NUM_LANES-1:0] in_run_d;
  code_arr_t            win_lo_d;
  code_arr_t            win_hi_d;
  code_arr_t            center_d;
  code_arr_t            center_c;
  logic [NUM_LANES-1:0] mism;
  logic [IDX_W-1:0]     idx_nxt;

  // Midpoint at DLY_WIDTH+1 bits so lo+hi cannot overflow before the shift.
  function automatic logic [DLY_WIDTH-1:0] midpoint(input logic [DLY_WIDTH-1:0] lo,
                                                    input logic [DLY_WIDTH-1:0] hi);
    logic [DLY_WIDTH:0] sum;
    sum = {1'b0, lo} + {1'b0, hi};
    return sum[DLY_WIDTH:1];
  endfunction

  always_comb begin
    mism = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      mism[i] = (rx_data[4*i +: 4] != PATTERN);
    end
  end

  // Only the first passing run is tracked: once found is set and in_run has
  // dropped, later passing steps leave the window untouched.
  always_comb begin
    found_d  = found_q;
    in_run_d = in_run_q;
    win_lo_d = win_lo_q;
    win_hi_d = win_hi_q;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (fail_q[i]) begin
        in_run_d[i] = 1'b0;
      end else if (!found_q[i]) begin
        win_lo_d[i] = cur_q;
        win_hi_d[i] = cur_q;
        found_d[i]  = 1'b1;
        in_run_d[i] = 1'b1;
      end else if (in_run_q[i]) begin
        win_hi_d[i] = cur_q;
      end
    end
  end

  always_comb begin
    center_d = '0;
    center_c = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      center_d[i] = midpoint(win_lo_d[i], win_hi_d[i]);
      center_c[i] = midpoint(win_lo_q[i], win_hi_q[i]);
    end
  end

  assign idx_nxt = idx_q + IDX_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cur_q    <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      fail_q   <= '0;
      found_q  <= '0;
      in_run_q <= '0;
      win_lo_q <= '0;
      win_hi_q <= '0;
      dly_q    <= '0;
      ld_q     <= '0;
      set_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // Strobes are single-cycle unless a state below re-asserts them.
      ld_q   <= '0;
      set_q  <= 1'b0;
      done_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (start) begin
            cur_q    <= '0;
            fail_q   <= '0;
            found_q  <= '0;
            in_run_q <= '0;
            win_lo_q <= '0;
            win_hi_q <= '0;
            dly_q    <= '0;
            ld_q     <= '1;
            state_q  <= StLoad;
          end
        end

        StLoad: begin
          set_q   <= 1'b1;
          state_q <= StSet;
        end

        StSet: begin
          cnt_q   <= '0;
          state_q <= StSettle;
        end

        StSettle: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_q   <= '0;
            state_q <= StSample;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        StSample: begin
          fail_q <= fail_q | mism;
          if (cnt_q == SAMPLE_LAST) begin
            cnt_q   <= '0;
            state_q <= StNext;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        StNext: begin
          found_q  <= found_d;
          in_run_q <= in_run_d;
          win_lo_q <= win_lo_d;
          win_hi_q <= win_hi_d;
          if (cur_q == LAST_CODE) begin
            // First APPLY cycle presents lane 0 using the just-updated window.
            idx_q    <= '0;
            dly_q    <= center_d[0];
            ld_q[0]  <= found_d[0];
            state_q  <= StApply;
          end else begin
            cur_q   <= cur_q + DLY_WIDTH'(1);
            dly_q   <= cur_q + DLY_WIDTH'(1);
            ld_q    <= '1;
            fail_q  <= '0;
            state_q <= StLoad;
          end
        end

        StApply: begin
          if (idx_q == LANE_LAST) begin
            set_q   <= 1'b1;
            state_q <= StApplySet;
          end else begin
            idx_q         <= idx_nxt;
            dly_q         <= center_c[idx_nxt];
            ld_q[idx_nxt] <= found_q[idx_nxt];
          end
        end

        StApplySet: begin
          done_q  <= 1'b1;
          state_q <= StDone;
        end

        StDone: begin
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign dly     = dly_q;
  assign ld      = ld_q;
  assign set     = set_q;
  assign done    = done_q;
  assign busy    = (state_q != StIdle);
  assign lane_ok = found_q;
  assign win_lo  = win_lo_q;
  assign win_hi  = win_hi_q;
  assign center  = center_c;

endmodule

// File: tb/tb_dqs_dly_calib.sv
module tb_dqs_dly_calib;

  localparam int unsigned NL       = 2;
  localparam int unsigned DW       = 8;
  localparam int unsigned DMAX     = 7;
  localparam int unsigned SC       = 2;
  localparam int unsigned SP       = 4;
  localparam int unsigned L        = 3 + SC + SP;
  localparam int unsigned SWEEP    = (DMAX + 1) * L;
  localparam int unsigned DONE_CYC = 1 + SWEEP + NL + 1;
  localparam int unsigned SAMP0    = 2 + SC;
  localparam logic [3:0]  PAT      = 4'b0101;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [4*NL-1:0]   rx_data;
  logic [DW-1:0]     dly;
  logic [NL-1:0]     ld;
  logic              set;
  logic              busy;
  logic              done;
  logic [NL-1:0]     lane_ok;
  logic [DW*NL-1:0]  win_lo;
  logic [DW*NL-1:0]  win_hi;
  logic [DW*NL-1:0]  center;
  logic [62:0]       all_o;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  dqs_dly_calib #(
    .NUM_LANES    (NL),
    .DLY_WIDTH    (DW),
    .DLY_MAX      (DMAX),
    .SETTLE_CYCLES(SC),
    .SAMPLE_CYCLES(SP),
    .PATTERN      (PAT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .rx_data(rx_data),
    .dly    (dly),
    .ld     (ld),
    .set    (set),
    .busy   (busy),
    .done   (done),
    .lane_ok(lane_ok),
    .win_lo (win_lo),
    .win_hi (win_hi),
    .center (center)
  );

  always #5 clk = ~clk;

  assign all_o = {dly, ld, set, busy, done, lane_ok, win_lo, win_hi, center};

  typedef struct {
    string      name;
    logic [7:0] pass0;
    logic [7:0] pass1;
    bit         glitch;
    int         gcode;
    int         gpos;
    logic [1:0] ok;
    logic [7:0] lo0, hi0, c0;
    logic [7:0] lo1, hi1, c1;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: first contiguous run of passing codes, centre by plain arithmetic.
  function automatic void first_run(input logic [7:0] p, output logic ok,
                                    output logic [7:0] lo, output logic [7:0] hi,
                                    output logic [7:0] c);
    int s, e;
    s = -1;
    e = -1;
    for (int k = 0; k <= int'(DMAX); k++) begin
      if (s < 0 && p[k]) begin
        s = k;
        e = k;
      end else if (s >= 0 && e == k - 1 && p[k]) begin
        e = k;
      end
    end
    ok = (s >= 0);
    lo = ok ? 8'(s) : 8'd0;
    hi = ok ? 8'(e) : 8'd0;
    c  = 8'((int'(lo) + int'(hi)) / 2);
  endfunction

  task automatic run_sweep(input string tag, input logic [7:0] p0, input logic [7:0] p1,
                           input bit g, input int gc, input int gp, input int abort_c,
                           input logic [1:0] e_ok,
                           input logic [7:0] lo0, input logic [7:0] hi0, input logic [7:0] c0,
                           input logic [7:0] lo1, input logic [7:0] hi1, input logic [7:0] c1);
    int         fpos [NL][DMAX+1];
    logic [7:0] pm   [NL];
    logic [7:0] ec   [NL];
    int         done_at, terr, first_bad, step, pos, li;
    logic [1:0] x_ld;
    logic       x_set, x_done, x_busy, chk_dly, bad;
    logic [7:0] x_dly;
    pm[0] = p0;
    pm[1] = p1;
    ec[0] = c0;
    ec[1] = c1;
    for (int l = 0; l < int'(NL); l++)
      for (int k = 0; k <= int'(DMAX); k++) fpos[l][k] = int'($urandom_range(SP - 1, 0));
    done_at   = -1;
    terr      = 0;
    first_bad = -1;

    @(posedge clk);
    #1;
    start   = 1'b1;
    rx_data = 4*NL'($urandom);
    for (int c = 1; c <= int'(DONE_CYC) + 4; c++) begin
      @(posedge clk);
      #1;
      if (c == int'(DONE_CYC)) start = 1'b1;
      else if (c < int'(DONE_CYC)) start = ($urandom_range(3, 0) == 0);
      else start = 1'b0;
      rx_data = 4*NL'($urandom);
      step    = (c - 1) / int'(L);
      pos     = (c - 1) % int'(L);
      if (c <= int'(SWEEP) && pos >= int'(SAMP0) && pos < int'(SAMP0 + SP)) begin
        for (int l = 0; l < int'(NL); l++) begin
          if (!pm[l][step]) bad = (pos - int'(SAMP0) == fpos[l][step]);
          else bad = g && l == 0 && step == gc && (pos - int'(SAMP0) == gp);
          rx_data[4*l +: 4] = bad ? (PAT ^ 4'($urandom_range(15, 1))) : PAT;
        end
      end

      if (c == abort_c) begin
        #2 rst = 1'b0;
        #1 chk({tag, " async reset clears outputs"}, 64'(all_o), 64'd0);
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk({tag, " outputs held in reset"}, 64'(all_o), 64'd0);
        start = 1'b0;
        rst   = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk({tag, " quiet after reset"}, 64'(all_o), 64'd0);
        return;
      end

      x_ld    = '0;
      x_set   = 1'b0;
      x_done  = 1'b0;
      x_busy  = (c <= int'(DONE_CYC));
      chk_dly = 1'b0;
      x_dly   = '0;
      if (c <= int'(SWEEP)) begin
        if (pos == 0) begin
          x_ld    = '1;
          chk_dly = 1'b1;
          x_dly   = 8'(step);
        end
        x_set = (pos == 1);
      end else if (c <= int'(SWEEP + NL)) begin
        li        = c - int'(SWEEP) - 1;
        x_ld[li]  = e_ok[li];
        chk_dly   = 1'b1;
        x_dly     = ec[li];
      end else if (c == int'(SWEEP + NL + 1)) begin
        x_set = 1'b1;
      end else if (c == int'(DONE_CYC)) begin
        x_done = 1'b1;
      end
      if (ld !== x_ld || set !== x_set || done !== x_done || busy !== x_busy ||
          (chk_dly && dly !== x_dly)) begin
        terr++;
        if (first_bad < 0) first_bad = c;
      end
      if (done === 1'b1 && done_at < 0) done_at = c;
    end

    chk($sformatf("%s strobe trace (first bad cycle %0d)", tag, first_bad), 64'(terr), 64'd0);
    chk({tag, " done cycle"}, 64'(done_at), 64'(DONE_CYC));
    chk({tag, " lane_ok"}, 64'(lane_ok), 64'(e_ok));
    chk({tag, " win_lo"}, 64'(win_lo), 64'({lo1, lo0}));
    chk({tag, " win_hi"}, 64'(win_hi), 64'({hi1, hi0}));
    chk({tag, " center"}, 64'(center), 64'({c1, c0}));
  endtask

  vec_t tbl [5];

  initial begin
    logic       ok0, ok1;
    logic [7:0] a0, b0, m0, a1, b1, m1, r0, r1;

    tbl[0] = '{"timing", 8'b0011_1100, 8'hFF, 1'b0, 0, 0, 2'b11,
               8'd2, 8'd5, 8'd3, 8'd0, 8'd7, 8'd3};
    tbl[1] = '{"split", 8'b1110_0110, 8'hFF, 1'b0, 0, 0, 2'b11,
               8'd1, 8'd2, 8'd1, 8'd0, 8'd7, 8'd3};
    tbl[2] = '{"dead lane", 8'hFF, 8'h00, 1'b0, 0, 0, 2'b01,
               8'd0, 8'd7, 8'd3, 8'd0, 8'd0, 8'd0};
    tbl[3] = '{"glitch", 8'hFF, 8'hFF, 1'b1, 3, 2, 2'b11,
               8'd0, 8'd2, 8'd1, 8'd0, 8'd7, 8'd3};
    tbl[4] = '{"edge codes", 8'h80, 8'h01, 1'b0, 0, 0, 2'b11,
               8'd7, 8'd7, 8'd7, 8'd0, 8'd0, 8'd0};

    rst     = 1'b1;
    start   = 1'b0;
    rx_data = '0;
    #2 rst  = 1'b0;
    start   = 1'b1;
    rx_data = 4*NL'($urandom);
    #1 chk("reset state", 64'(all_o), 64'd0);
    repeat (3) @(posedge clk);
    #1 chk("reset held with start", 64'(all_o), 64'd0);
    start = 1'b0;
    rst   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      rx_data = 4*NL'($urandom);
      chk($sformatf("idle hold cycle %0d", i), 64'(all_o), 64'd0);
    end

    for (int i = 0; i < 5; i++) begin
      run_sweep(tbl[i].name, tbl[i].pass0, tbl[i].pass1, tbl[i].glitch, tbl[i].gcode,
                tbl[i].gpos, -1, tbl[i].ok, tbl[i].lo0, tbl[i].hi0, tbl[i].c0,
                tbl[i].lo1, tbl[i].hi1, tbl[i].c1);
    end

    for (int i = 0; i < 6; i++) begin
      r0 = 8'($urandom);
      r1 = 8'($urandom);
      first_run(r0, ok0, a0, b0, m0);
      first_run(r1, ok1, a1, b1, m1);
      run_sweep($sformatf("random %0d", i), r0, r1, 1'b0, 0, 0, -1, {ok1, ok0},
                a0, b0, m0, a1, b1, m1);
    end

    // Abort in the first SAMPLE cycle of code 4, then a clean full sweep.
    run_sweep("abort", 8'hFF, 8'hFF, 1'b0, 0, 0, 1 + 4 * int'(L) + int'(SAMP0),
              2'b11, 8'd0, 8'd7, 8'd3, 8'd0, 8'd7, 8'd3);
    run_sweep("after abort", tbl[0].pass0, tbl[0].pass1, 1'b0, 0, 0, -1, tbl[0].ok,
              tbl[0].lo0, tbl[0].hi0, tbl[0].c0, tbl[0].lo1, tbl[0].hi1, tbl[0].c1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dqs_dly_calib.md
# dqs_dly_calib

Parametrised per-lane delay calibration sequencer for the DQS/DQ test path. It sweeps a shared delay value across all lanes, loading and setting the delay lines at every step. At each step it checks the deserialized receive data of every lane against a fixed pattern, records each lane's first contiguous passing window, and finally loads each passing lane with its window centre. It runs in the divided-clock domain, between the delay-line load/set controls and the deserializer outputs.

## Interface
Parameters:
- NUM_LANES, 4, number of independently calibrated lanes
- DLY_WIDTH, 8, delay code width
- DLY_MAX, 255, last delay code swept (inclusive), DLY_MAX < 2**DLY_WIDTH
- SETTLE_CYCLES, 16, wait cycles after each set before sampling, >= 1
- SAMPLE_CYCLES, 64, compare cycles per step, >= 1
- PATTERN, 4'b0101, expected 4-bit deserialized word per lane per cycle

Ports:
- clk  in  1  divided clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin sweep; sampled only in IDLE
- rx_data  in  4*NUM_LANES  deserialized receive words, lane i at [4i+3:4i]
- dly  out  DLY_WIDTH  delay code presented to all delay lines
- ld  out  NUM_LANES  per-lane load strobe; loads dly
- set  out  1  applies loaded delays in all lanes
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at sweep completion
- lane_ok  out  NUM_LANES  lane found at least one passing step
- win_lo  out  DLY_WIDTH*NUM_LANES  first code of first passing run, per lane
- win_hi  out  DLY_WIDTH*NUM_LANES  last code of first passing run, per lane
- center  out  DLY_WIDTH*NUM_LANES  (win_lo+win_hi)>>1, per lane

## Operation
- States: IDLE, LOAD, SET, SETTLE, SAMPLE, NEXT, APPLY, APPLY_SET, DONE.
- IDLE: if start=1, the block clears lane_ok, win_lo, win_hi, center, the per-lane found/in-run flags and the step code cur. It then goes to LOAD.
- LOAD, 1 cycle: dly=cur, ld=all ones, then SET.
- SET, 1 cycle: set=1, then SETTLE.
- SETTLE: lasts SETTLE_CYCLES cycles, then SAMPLE.
- SAMPLE: lasts SAMPLE_CYCLES cycles.
  - Per-lane fail flag is set when rx_data lane != PATTERN in any cycle.
  - Fail flags are cleared on entry to LOAD.
- NEXT, 1 cycle, per lane:
  - Pass and not found: win_lo=win_hi=cur, found=1, in_run=1.
  - Pass and in_run: win_hi=cur.
  - Fail: in_run=0.
  - A later run after the first one closes is ignored.
  - If cur==DLY_MAX go to APPLY with lane index 0; otherwise cur+=1 and go to LOAD. No wrap past DLY_MAX.
- lane_ok = found. center is computed at DLY_WIDTH+1 bits, then truncated; it is valid from the cycle after the final NEXT.
- APPLY: one cycle per lane, i = 0..NUM_LANES-1.
  - dly=center[i].
  - ld[i]=lane_ok[i]; failing lanes get no ld and keep the last swept code.
- APPLY_SET, 1 cycle: set=1.
- DONE, 1 cycle: done=1, then IDLE.
- Result outputs hold until the next accepted start or reset.
- start outside IDLE is ignored, including during DONE.

## Timing
- Reset values: dly=0, ld=0, set=0, busy=0, done=0, lane_ok=0, win_lo=0, win_hi=0, center=0, state IDLE.
- Reset mid-operation forces these values immediately, independent of clk; no ld/set is issued after reset.
- ld, set, done and dly are registered outputs.
- Step length L = 3+SETTLE_CYCLES+SAMPLE_CYCLES.
- Start is sampled at edge 0, and LOAD is active in cycle 1.
- done is high in cycle 1+(DLY_MAX+1)*L+NUM_LANES+1.
- busy rises in cycle 1 and falls in the cycle after done.
- rx_data is compared in the same cycle it is sampled; there is no pipeline compensation. SETTLE_CYCLES must cover the serdes and delay-line latency.

## Test plan
- Reset check: assert rst=0 with random inputs, then release. All outputs are at reset values, and the block holds idle with start=0.
- Timing check (NUM_LANES=2, DLY_MAX=7, SETTLE=2, SAMPLE=4):
  - Model lane0 passing at codes 2..5 and lane1 at 0..7.
  - Expected: done at cycle 76, lane_ok=2'b11, win0 2/5, center0=3, win1 0/7, center1=3.
  - APPLY issues ld=01 with dly=3, then ld=10 with dly=3, then set.
- Split window: lane0 passes at codes 1..2 and 5..7. Expected win_lo=1, win_hi=2, center=1; the second run is ignored.
- Dead lane: lane1 never passes. Expected lane_ok[1]=0, win/center for lane1 = 0, and ld[1] never high during APPLY.
- Glitch and start filtering:
  - A single-cycle rx mismatch in the third SAMPLE cycle at code 3 fails that step. With a pass range of 0..7, this gives win 0/2.
  - start pulses while busy are ignored.
- Reset during SAMPLE at code 4: outputs clear immediately. A following start runs a full sweep with cycle count 76.
